dcache_sram_arbiter: RTL and testbench
======================================

Name: dcache_sram_arbiter

Overview:
- Arbitrates NR_PORTS requesters onto the single shared dcache SRAM port: data, tag and valid/dirty/shared arrays.
- Requesters, highest priority first: miss handler, snoop controller, PTW, load, store.
- Fixed priority with optional anti-starvation aging.
- Per-port lock so a winner can hold the array across read-modify-write sequences.
- Registers the winning port so read data and hit info can be steered one cycle later.

Parameters:
- NR_PORTS, 5, number of requesters; port 0 has highest priority.
- ADDR_WIDTH, 12, SRAM index width (DCACHE_INDEX_WIDTH).
- DATA_WIDTH, 128, flattened cache_line_t width.
- BE_WIDTH, 16, flattened cl_be_t width.
- NR_WAYS, 8, way-select width (DCACHE_SET_ASSOC).
- STARVE_LIMIT, 15, cycles a port may wait before it is promoted.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- req_i  in  NR_PORTS x NR_WAYS  per-port way request; a port requests when any bit is set
- lock_i  in  NR_PORTS  hold the grant after this access
- we_i  in  NR_PORTS  write enable
- addr_i  in  NR_PORTS x ADDR_WIDTH  index
- wdata_i  in  NR_PORTS x DATA_WIDTH  write data
- be_i  in  NR_PORTS x BE_WIDTH  byte enables
- gnt_o  out  NR_PORTS  one-hot grant, same cycle as the request
- rvalid_o  out  NR_PORTS  one-hot; asserted the cycle after a granted read
- req_o  out  NR_WAYS  SRAM way request
- we_o  out  1  SRAM write enable
- addr_o  out  ADDR_WIDTH  SRAM index
- wdata_o  out  DATA_WIDTH  SRAM write data
- be_o  out  BE_WIDTH  SRAM byte enables
- rport_o  out  $clog2(NR_PORTS)  port owning the read data this cycle
- busy_o  out  1  arbiter is in LOCKED

Behaviour:
- Reset (rst_ni low at a clk_i edge): state IDLE, all aging counters 0, rvalid_o 0, rport_o 0. All combinational outputs are 0 while no request is present.
- Grant is combinational. The SRAM outputs mux the winner's fields in the same cycle. When there is no winner, req_o and we_o are 0 and the other SRAM outputs are 0.
- IDLE state:
  - Winner is the lowest-indexed requesting port, unless the aging rule applies.
  - If winner w has lock_i[w]=1, go to LOCKED with owner=w.
- LOCKED state:
  - Only the owner can be granted; gnt_o is 0 for every other port.
  - The owner keeps the lock while it requests with lock_i=1.
  - Return to IDLE when the owner presents a request with lock_i=0 (that access is still granted) or deasserts req_i entirely.
  - Lock release and a new IDLE grant never happen in the same cycle. The next winner is chosen in the following cycle.
- Read return:
  - On a granted access with we=0: rvalid_o[w]=1 and rport_o=w in the next cycle.
  - Granted writes never raise rvalid_o.
  - Back-to-back reads from different ports give one rvalid per cycle, in grant order.
- Request stability: a requester keeps req/addr/we/wdata/be stable until granted. The arbiter does not register requests.
- Simultaneous events:
  - All ports requesting in IDLE: port 0 wins.
  - Lock request and a promoted port in the same cycle: the promoted port wins. The lock takes effect only if the promoted port itself asserts lock_i.
- Reset mid-LOCKED: returns to IDLE and clears rvalid_o on the next edge.

Optional Feature:
- DCACHE_ARB_AGING_EN defined:
  - Each port has a 4-bit saturating counter ($clog2(STARVE_LIMIT+1) bits).
  - It increments each cycle the port requests and is not granted in IDLE.
  - It clears on grant or when the port drops its request.
  - Any port whose counter equals STARVE_LIMIT is promoted. Among promoted ports, the lowest index wins, pre-empting fixed priority.
  - Counters freeze while LOCKED.
- DCACHE_ARB_AGING_EN undefined: pure fixed priority, no counters (zero flops).

Decomposition:
- Package std_cache_pkg gets:
  - arb_state_e {IDLE, LOCKED}
  - DCACHE_ARB_PORTS=5
  - port index constants ARB_MISS=0, ARB_SNOOP=1, ARB_PTW=2, ARB_LOAD=3, ARB_STORE=4
- Sub-module dcache_arb_prio: combinational lowest-index-wins one-hot picker plus index encoder. It is instantiated twice: once for normal requests, once for promoted requests.

Test Plan:
- Ports 3 and 4 request reads at addr 0x010 and 0x020 in the same cycle:
  - gnt_o=5'b01000, addr_o=0x010.
  - Next cycle: rvalid_o[3]=1, rport_o=3, gnt_o=5'b10000.
- Port 0 requests with lock_i=1 for 3 cycles while port 3 requests:
  - gnt_o[3]=0 and busy_o=1 throughout the lock.
  - Port 0 then drops lock_i and is still granted; port 3 is granted in the following cycle.
- Port 4 write (we=1, be=all ones) granted: we_o=1, wdata_o equals port 4 data, rvalid_o stays 0 in the next cycle.
- With DCACHE_ARB_AGING_EN, port 2 requests continuously against a permanent port 1 request:
  - Port 2 is granted on cycle 16 (after 15 denials).
  - Its counter returns to 0 and port 1 is granted on the following cycle.
- rst_ni driven low for 1 cycle while LOCKED with owner 1:
  - Next cycle: busy_o=0, rvalid_o=0.
  - A port 3 request is granted immediately.
- No requests for 10 cycles: req_o=0, we_o=0, gnt_o=0, rvalid_o=0.

Source files
------------

// File: rtl/std_cache_pkg.sv
// Shared dcache arbitration types: port count, requester indices and arbiter FSM states.
package std_cache_pkg;

  localparam int unsigned DCACHE_ARB_PORTS = 5;

  localparam int unsigned ARB_MISS  = 0;
  localparam int unsigned ARB_SNOOP = 1;
  localparam int unsigned ARB_PTW   = 2;
  localparam int unsigned ARB_LOAD  = 3;
  localparam int unsigned ARB_STORE = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dcache_arb_prio.sv
// Lowest-index-wins picker: one-hot grant, binary index of the winner, and an any-request flag.
module dcache_arb_prio #(
  parameter int unsigned N = 5,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = |req;
    // Scan from the top so the last hit, the lowest index, is what remains.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/dcache_sram_arbiter.sv
// Fixed-priority arbiter for the shared dcache SRAM port with per-port lock and registered read steering.
// Optional anti-starvation aging is enabled by defining DCACHE_ARB_AGING_EN.
module dcache_sram_arbiter
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_PORTS     = DCACHE_ARB_PORTS,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 128,
  parameter int unsigned BE_WIDTH     = 16,
  parameter int unsigned NR_WAYS      = 8,
  parameter int unsigned STARVE_LIMIT = 15,
  localparam int unsigned PW = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NR_PORTS-1:0][NR_WAYS-1:0]     req_i,
  input  logic [NR_PORTS-1:0]                  lock_i,
  input  logic [NR_PORTS-1:0]                  we_i,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]  addr_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]  wdata_i,
  input  logic [NR_PORTS-1:0][BE_WIDTH-1:0]    be_i,
  output logic [NR_PORTS-1:0]                  gnt_o,
  output logic [NR_PORTS-1:0]                  rvalid_o,
  output logic [NR_WAYS-1:0]                   req_o,
  output logic                                 we_o,
  output logic [ADDR_WIDTH-1:0]                addr_o,
  output logic [DATA_WIDTH-1:0]                wdata_o,
  output logic [BE_WIDTH-1:0]                  be_o,
  output logic [PW-1:0]                        rport_o,
  output logic                                 busy_o
);

  arb_state_e            state_q;
  logic [NR_PORTS-1:0]   owner_q;
  logic [NR_PORTS-1:0]   rvalid_q;
  logic [PW-1:0]         rport_q;

  logic [NR_PORTS-1:0]   req_any, eligible, promoted;
  logic [NR_PORTS-1:0]   norm_gnt, prom_gnt, win_gnt;
  logic [PW-1:0]         norm_idx, prom_idx, win_idx;
  logic                  norm_any, prom_any, win_any;
  logic                  win_we, win_lock, owner_req, owner_lock;

  always_comb begin
    req_any = '0;
    for (int p = 0; p < NR_PORTS; p++) req_any[p] = |req_i[p];
  end

  // While locked only the owner is eligible, and aging never pre-empts it.
  assign eligible = (state_q == LOCKED) ? (req_any & owner_q) : req_any;

`ifdef DCACHE_ARB_AGING_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] age_q [NR_PORTS];

  always_comb begin
    promoted = '0;
    for (int p = 0; p < NR_PORTS; p++)
      promoted[p] = (state_q == IDLE) && req_any[p] && (age_q[p] == CW'(STARVE_LIMIT));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int p = 0; p < NR_PORTS; p++) age_q[p] <= '0;
    end else if (state_q == IDLE) begin
      for (int p = 0; p < NR_PORTS; p++) begin
        if (!req_any[p] || win_gnt[p]) age_q[p] <= '0;
        else if (age_q[p] != CW'(STARVE_LIMIT)) age_q[p] <= age_q[p] + 1'b1;
      end
    end
  end
`else
  assign promoted = '0;
`endif

  dcache_arb_prio #(.N(NR_PORTS)) u_prio_norm (
    .req (eligible),
    .gnt (norm_gnt),
    .idx (norm_idx),
    .any (norm_any)
  );

  dcache_arb_prio #(.N(NR_PORTS)) u_prio_prom (
    .req (promoted),
    .gnt (prom_gnt),
    .idx (prom_idx),
    .any (prom_any)
  );

  assign win_gnt    = prom_any ? prom_gnt : norm_gnt;
  assign win_idx    = prom_any ? prom_idx : norm_idx;
  assign win_any    = prom_any | norm_any;
  assign win_we     = |(win_gnt & we_i);
  assign win_lock   = |(win_gnt & lock_i);
  assign owner_req  = |(owner_q & req_any);
  assign owner_lock = |(owner_q & lock_i);

  always_comb begin
    req_o   = '0;
    we_o    = 1'b0;
    addr_o  = '0;
    wdata_o = '0;
    be_o    = '0;
    for (int p = 0; p < NR_PORTS; p++) begin
      if (win_gnt[p]) begin
        req_o   = req_i[p];
        we_o    = we_i[p];
        addr_o  = addr_i[p];
        wdata_o = wdata_i[p];
        be_o    = be_i[p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rvalid_q <= '0;
      rport_q  <= '0;
    end else begin
      rvalid_q <= (win_any && !win_we) ? win_gnt : '0;
      rport_q  <= (win_any && !win_we) ? win_idx : '0;
      case (state_q)
        IDLE: begin
          if (win_any && win_lock) begin
            state_q <= LOCKED;
            owner_q <= win_gnt;
          end
        end
        LOCKED: begin
          // Release takes effect next cycle; the release access itself is still granted.
          if (!owner_req || !owner_lock) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o    = win_gnt;
  assign rvalid_o = rvalid_q;
  assign rport_o  = rport_q;
  assign busy_o   = (state_q == LOCKED);

endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// Directed bench for dcache_sram_arbiter: behavioural arbitration model checked every cycle plus literal checks.
module tb_dcache_sram_arbiter;

  localparam int NP = 5;
  localparam int AW = 12;
  localparam int DW = 128;
  localparam int BW = 16;
  localparam int NW = 8;
  localparam int SL = 15;

  logic                    clk;
  logic                    rst_ni;
  logic [NP-1:0][NW-1:0]   req_i;
  logic [NP-1:0]           lock_i;
  logic [NP-1:0]           we_i;
  logic [NP-1:0][AW-1:0]   addr_i;
  logic [NP-1:0][DW-1:0]   wdata_i;
  logic [NP-1:0][BW-1:0]   be_i;
  logic [NP-1:0]           gnt_o;
  logic [NP-1:0]           rvalid_o;
  logic [NW-1:0]           req_o;
  logic                    we_o;
  logic [AW-1:0]           addr_o;
  logic [DW-1:0]           wdata_o;
  logic [BW-1:0]           be_o;
  logic [2:0]              rport_o;
  logic                    busy_o;

  dcache_sram_arbiter dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .lock_i   (lock_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .be_i     (be_i),
    .gnt_o    (gnt_o),
    .rvalid_o (rvalid_o),
    .req_o    (req_o),
    .we_o     (we_o),
    .addr_o   (addr_o),
    .wdata_o  (wdata_o),
    .be_o     (be_o),
    .rport_o  (rport_o),
    .busy_o   (busy_o)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: lock owner, aging counts, and expected read-return queue
  bit         m_ready = 0;
  bit         m_locked;
  int         m_owner;
  int         m_age [NP];
  logic [2:0] exp_q [$];
  int         mw;
  logic [NP-1:0] exp_gnt;
  logic [2:0] ep;

  function automatic int model_winner();
    if (m_locked) return (|req_i[m_owner]) ? m_owner : -1;
`ifdef DCACHE_ARB_AGING_EN
    for (int p = 0; p < NP; p++)
      if ((|req_i[p]) && m_age[p] == SL) return p;
`endif
    for (int p = 0; p < NP; p++)
      if (|req_i[p]) return p;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_ni) begin
      m_locked = 0;
      m_owner  = 0;
      for (int p = 0; p < NP; p++) m_age[p] = 0;
      exp_q.delete();
      m_ready  = 1;
    end else if (m_ready) begin
      mw = model_winner();
      exp_gnt = '0;
      if (mw >= 0) exp_gnt[mw] = 1'b1;
      chk("m_gnt", gnt_o, exp_gnt);
      chk("m_req", req_o, (mw >= 0) ? req_i[mw] : '0);
      chk("m_we", we_o, (mw >= 0) ? we_i[mw] : 1'b0);
      chk("m_addr", addr_o, (mw >= 0) ? addr_i[mw] : '0);
      chk("m_wdata", wdata_o, (mw >= 0) ? wdata_i[mw] : '0);
      chk("m_be", be_o, (mw >= 0) ? be_i[mw] : '0);
      chk("m_busy", busy_o, m_locked);
      if (exp_q.size() > 0) begin
        ep = exp_q.pop_front();
        chk("m_rvalid", rvalid_o, NP'(1) << ep);
        chk("m_rport", rport_o, ep);
      end else begin
        chk("m_rvalid", rvalid_o, '0);
      end
      if (mw >= 0 && !we_i[mw]) exp_q.push_back(3'(mw));
      if (!m_locked) begin
        for (int p = 0; p < NP; p++)
          m_age[p] = ((|req_i[p]) && p != mw) ? ((m_age[p] < SL) ? m_age[p] + 1 : SL) : 0;
        if (mw >= 0 && lock_i[mw]) begin
          m_locked = 1;
          m_owner  = mw;
        end
      end else if (!(|req_i[m_owner]) || !lock_i[m_owner]) begin
        m_locked = 0;
      end
    end
  end

  // Driver tasks
  task automatic drive(input int p, input logic [AW-1:0] a, input logic w, input logic l,
                       input logic [DW-1:0] d);
    req_i[p]   = 8'(8'h01 << p);
    addr_i[p]  = a;
    we_i[p]    = w;
    lock_i[p]  = l;
    wdata_i[p] = d;
    be_i[p]    = w ? 16'hFFFF : 16'h0F0F;
  endtask

  task automatic drop(input int p);
    req_i[p]   = '0;
    addr_i[p]  = '0;
    we_i[p]    = 1'b0;
    lock_i[p]  = 1'b0;
    wdata_i[p] = '0;
    be_i[p]    = '0;
  endtask

  task automatic clr_all();
    for (int p = 0; p < NP; p++) drop(p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  typedef struct {
    logic [NP-1:0] req;
    logic [NP-1:0] we;
    logic [NP-1:0] gnt;
  } vec_t;

  vec_t vecs [4];

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    vecs[0] = '{req: 5'b11111, we: 5'b00000, gnt: 5'b00001};
    vecs[1] = '{req: 5'b10110, we: 5'b00010, gnt: 5'b00010};
    vecs[2] = '{req: 5'b11000, we: 5'b11000, gnt: 5'b01000};
    vecs[3] = '{req: 5'b10000, we: 5'b00000, gnt: 5'b10000};

    rst_ni = 1'b0;
    clr_all();
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Reset state
    sample();
    chk("rst_gnt", gnt_o, '0);
    chk("rst_rvalid", rvalid_o, '0);
    chk("rst_rport", rport_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_req", req_o, '0);
    tick();

    // Two simultaneous reads: port 3 first, then port 4
    drive(3, 12'h010, 1'b0, 1'b0, {4{32'h3333_0000}});
    drive(4, 12'h020, 1'b0, 1'b0, {4{32'h4444_0000}});
    sample();
    chk("rd_gnt3", gnt_o, 5'b01000);
    chk("rd_addr3", addr_o, 12'h010);
    tick(); drop(3);
    sample();
    chk("rd_rvalid3", rvalid_o, 5'b01000);
    chk("rd_rport3", rport_o, 3'd3);
    chk("rd_gnt4", gnt_o, 5'b10000);
    chk("rd_addr4", addr_o, 12'h020);
    tick(); drop(4);
    sample();
    chk("rd_rvalid4", rvalid_o, 5'b10000);
    chk("rd_rport4", rport_o, 3'd4);
    tick();

    // Port 0 holds the lock for three cycles while port 3 waits
    drive(0, 12'h100, 1'b0, 1'b1, '0);
    drive(3, 12'h030, 1'b0, 1'b0, '0);
    sample();
    chk("lk_gnt_a", gnt_o, 5'b00001);
    chk("lk_busy_a", busy_o, 1'b0);
    tick();
    repeat (2) begin
      sample();
      chk("lk_gnt_held", gnt_o, 5'b00001);
      chk("lk_busy_held", busy_o, 1'b1);
      tick();
    end
    lock_i[0] = 1'b0;
    sample();
    chk("lk_gnt_release", gnt_o, 5'b00001);
    chk("lk_busy_release", busy_o, 1'b1);
    tick(); drop(0);
    sample();
    chk("lk_gnt_next", gnt_o, 5'b01000);
    chk("lk_busy_next", busy_o, 1'b0);
    tick(); drop(3);

    // Port 4 full-line write
    drive(4, 12'h3FF, 1'b1, 1'b0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
    sample();
    chk("wr_gnt", gnt_o, 5'b10000);
    chk("wr_we", we_o, 1'b1);
    chk("wr_wdata", wdata_o, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE);
    chk("wr_be", be_o, 16'hFFFF);
    tick(); drop(4);
    sample();
    chk("wr_no_rvalid", rvalid_o, '0);
    tick();

    // Port 2 against a permanent port 1 request
    drive(1, 12'h011, 1'b0, 1'b0, '0);
    drive(2, 12'h022, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 16; k++) begin
      sample();
`ifdef DCACHE_ARB_AGING_EN
      chk("age_gnt", gnt_o, (k == 16) ? 5'b00100 : 5'b00010);
`else
      chk("age_gnt", gnt_o, 5'b00010);
`endif
      tick();
    end
    drop(2);
    sample();
    chk("age_gnt_after", gnt_o, 5'b00010);
    tick(); drop(1);

    // Directed priority table
    foreach (vecs[i]) begin
      for (int p = 0; p < NP; p++)
        if (vecs[i].req[p]) drive(p, 12'(12'h100 + p), vecs[i].we[p], 1'b0, {4{32'(p + 1)}});
      sample();
      chk("tbl_gnt", gnt_o, vecs[i].gnt);
      tick();
      clr_all();
    end

    // Reset while locked by port 1
    drive(1, 12'h050, 1'b0, 1'b1, '0);
    sample();
    chk("rl_gnt1", gnt_o, 5'b00010);
    tick();
    drive(3, 12'h060, 1'b0, 1'b0, '0);
    sample();
    chk("rl_busy", busy_o, 1'b1);
    chk("rl_gnt_owner", gnt_o, 5'b00010);
    tick();
    rst_ni = 1'b0;
    sample();
    chk("rl_busy_in_rst", busy_o, 1'b1);
    tick();
    rst_ni = 1'b1;
    drop(1);
    sample();
    chk("rl_busy_after", busy_o, 1'b0);
    chk("rl_rvalid_after", rvalid_o, '0);
    chk("rl_gnt3", gnt_o, 5'b01000);
    tick(); drop(3);
    sample();
    tick();

    // Quiet bus
    repeat (10) begin
      sample();
      chk("idle_req", req_o, '0);
      chk("idle_we", we_o, 1'b0);
      chk("idle_gnt", gnt_o, '0);
      chk("idle_rvalid", rvalid_o, '0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
